// File: rtl/dist_ram_arb_pkg.sv
// Shared definitions for dist_ram_arbiter and its round-robin arbiter.
//   NUM_REQ_MAX - largest supported client count
//   clog2_min1  - ceil(log2(n)), never less than 1 (pointer width helper)
//   req_idx_t   - index type wide enough for any client number up to NUM_REQ_MAX
package dist_ram_arb_pkg;

    localparam int unsigned NUM_REQ_MAX = 8;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req [N]     request vector
//   advance     move the pointer past the current winner (tie to |gnt)
//   gnt [N]     one-hot grant, combinational; forced 0 while rst_n is low
module rr_arbiter
    import dist_ram_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = clog2_min1(N);

    logic [PW-1:0] ptr_q, ptr_d;
    req_idx_t      win;
    logic          found;

    // Scan offsets ptr, ptr+1, ... (mod N); the first requester wins.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (!found && req[k] && (((32'(ptr_q) + off) % N) == k)) begin
                    found  = 1'b1;
                    gnt[k] = 1'b1;
                    win    = req_idx_t'(k);
                end
            end
        end
        if (!rst_n) begin
            gnt = '0;
        end
    end

    always_comb begin
        if (32'(win) == N - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = PW'(32'(win) + 32'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dist_ram_arbiter.sv
// Shares one dist_ram (one write port, one async read port) between NUM_REQ clients with
// independent round-robin arbitration for writes and reads. Read data is registered and
// returned one cycle after the grant with a one-hot per-client valid.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data     per-client write requests (packed, client i at [i*W +: W])
//   wr_gnt                     one-hot write grant (combinational)
//   rd_req/rd_addr             per-client read requests
//   rd_gnt                     one-hot read grant (combinational)
//   rd_valid/rd_data           registered read response
//   ram_*                      connection to the dist_ram instance in the parent
// Optional feature: define RAW_BYPASS_EN to forward same-cycle write data to a colliding read.
module dist_ram_arbiter
    import dist_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DATA_DEPTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               wr_req,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
    output logic [NUM_REQ-1:0]               wr_gnt,
    input  logic [NUM_REQ-1:0]               rd_req,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]               rd_gnt,
    output logic [NUM_REQ-1:0]               rd_valid,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic [ADDRESS_WIDTH-1:0]         ram_in_addr,
    output logic [DATA_WIDTH-1:0]            ram_data_in,
    output logic                             ram_write_en,
    output logic [ADDRESS_WIDTH-1:0]         ram_out_addr,
    input  logic [DATA_WIDTH-1:0]            ram_data_out
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    logic                 wr_any, rd_any;
    logic                 wr_in_range, rd_in_range;
    logic [DW-1:0]        rd_word;
    logic [NUM_REQ-1:0]   rd_valid_q;
    logic [DW-1:0]        rd_data_q;

    assign wr_any = |wr_gnt;
    assign rd_any = |rd_gnt;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_wr_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (wr_req),
        .advance(wr_any),
        .gnt    (wr_gnt)
    );

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rd_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (rd_req),
        .advance(rd_any),
        .gnt    (rd_gnt)
    );

    // Grants are one-hot, so the muxes reduce to "pick the granted slice", 0 when idle.
    always_comb begin
        ram_in_addr  = '0;
        ram_data_in  = '0;
        ram_out_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                ram_in_addr = wr_addr[i*AW +: AW];
                ram_data_in = wr_data[i*DW +: DW];
            end
            if (rd_gnt[i]) begin
                ram_out_addr = rd_addr[i*AW +: AW];
            end
        end
    end

    assign wr_in_range  = 32'(ram_in_addr) < DATA_DEPTH;
    assign rd_in_range  = 32'(ram_out_addr) < DATA_DEPTH;
    // Out-of-range writes are still granted; only the RAM strobe is suppressed.
    assign ram_write_en = wr_any & wr_in_range;

`ifdef RAW_BYPASS_EN
    // ram_write_en already implies an in-range write, so an address match implies an
    // in-range read as well.
    logic raw_hit;
    assign raw_hit = ram_write_en && (ram_in_addr == ram_out_addr);
    assign rd_word = raw_hit ? ram_data_in : ram_data_out;
`else
    assign rd_word = ram_data_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_gnt;
            if (rd_any) begin
                rd_data_q <= rd_in_range ? rd_word : '0;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_dist_ram_arbiter.sv
// Self-checking bench for dist_ram_arbiter (4 clients, 8-bit words, 24 words, 5-bit address).
// The bench owns a behavioural RAM attached to the ram_* ports and an independent model of
// the expected memory contents and round-robin pointers.
module tb_dist_ram_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 24;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NREQ-1:0]      wr_req, rd_req;
    logic [NREQ*AW-1:0]   wr_addr, rd_addr;
    logic [NREQ*DW-1:0]   wr_data;
    logic [NREQ-1:0]      wr_gnt, rd_gnt, rd_valid;
    logic [DW-1:0]        rd_data;
    logic [AW-1:0]        ram_in_addr, ram_out_addr;
    logic [DW-1:0]        ram_data_in, ram_data_out;
    logic                 ram_write_en;

    logic [DW-1:0]        mem   [0:DEPTH-1];
    logic [DW-1:0]        m_mem [0:DEPTH-1];
    logic                 preload = 1'b0;
    logic [AW-1:0]        pl_addr = '0;
    logic [DW-1:0]        pl_data = '0;

    int checks   = 0;
    int failures = 0;

    dist_ram_arbiter #(
        .NUM_REQ      (NREQ),
        .DATA_WIDTH   (DW),
        .DATA_DEPTH   (DEPTH),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_gnt      (rd_gnt),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .ram_in_addr (ram_in_addr),
        .ram_data_in (ram_data_in),
        .ram_write_en(ram_write_en),
        .ram_out_addr(ram_out_addr),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural dist_ram: synchronous write, asynchronous read. Out-of-range reads return
    // a non-zero pattern so that the arbiter's zeroing is observable.
    always @(posedge clk) begin
        if (preload) mem[pl_addr] <= pl_data;
        else if (ram_write_en && int'(ram_in_addr) < DEPTH) mem[ram_in_addr] <= ram_data_in;
    end

    always_comb begin
        ram_data_out = 8'hEE;
        if (int'(ram_out_addr) < DEPTH) ram_data_out = mem[ram_out_addr];
    end

    // Winner = requester at the smallest cyclic distance from the pointer.
    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        int best  = -1;
        int bestd = NREQ;
        for (int k = 0; k < NREQ; k++) begin
            if (r[k] && ((k - ptr + NREQ) % NREQ) < bestd) begin
                bestd = (k - ptr + NREQ) % NREQ;
                best  = k;
            end
        end
        return best;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int k);
        logic [NREQ-1:0] r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    task automatic clear_reqs();
        wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic set_wr(input int c, input int a, input int d);
        wr_req[c] = 1'b1;
        wr_addr[c*AW +: AW] = AW'(a);
        wr_data[c*DW +: DW] = DW'(d);
    endtask

    task automatic set_rd(input int c, input int a);
        rd_req[c] = 1'b1;
        rd_addr[c*AW +: AW] = AW'(a);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_reqs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        after_edge();
    endtask

    task automatic do_preload();
        preload = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pl_addr = AW'(i);
            pl_data = DW'($urandom_range(1, 255));
            m_mem[i] = pl_data;
            after_edge();
        end
        preload = 1'b0;
    endtask

    task automatic test_reset();
        wr_req = '1; rd_req = '1;
        for (int c = 0; c < NREQ; c++) begin
            wr_addr[c*AW +: AW] = AW'(c + 1);
            wr_data[c*DW +: DW] = DW'(c + 8'h40);
            rd_addr[c*AW +: AW] = AW'(c + 2);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (wr_gnt !== 4'b0) begin failures++; $display("FAIL reset_wr_gnt got=%b exp=0000", wr_gnt); end
        checks++; if (rd_gnt !== 4'b0) begin failures++; $display("FAIL reset_rd_gnt got=%b exp=0000", rd_gnt); end
        after_edge();
        checks++; if (ram_write_en !== 1'b0) begin failures++; $display("FAIL reset_write_en got=%b exp=0", ram_write_en); end
        checks++; if (rd_valid !== 4'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0000", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if (ram_in_addr !== 5'd0 || ram_out_addr !== 5'd0) begin failures++;
            $display("FAIL reset_idle_mux got=%h/%h exp=00/00", ram_in_addr, ram_out_addr); end
        clear_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        after_edge();
    endtask

    task automatic test_write_read();
        apply_reset();
        set_wr(2, 5, 8'hA5);
        @(negedge clk);
        checks++; if (wr_gnt !== 4'b0100) begin failures++; $display("FAIL wr_gnt_single got=%b exp=0100", wr_gnt); end
        checks++; if (ram_write_en !== 1'b1) begin failures++; $display("FAIL wr_en_single got=%b exp=1", ram_write_en); end
        checks++; if (ram_in_addr !== 5'd5 || ram_data_in !== 8'hA5) begin failures++;
            $display("FAIL wr_mux_single got=%h/%h exp=05/a5", ram_in_addr, ram_data_in); end
        after_edge();
        m_mem[5] = 8'hA5;
        clear_reqs();
        set_rd(1, 5);
        @(negedge clk);
        checks++; if (rd_gnt !== 4'b0010) begin failures++; $display("FAIL rd_gnt_single got=%b exp=0010", rd_gnt); end
        checks++; if (ram_write_en !== 1'b0) begin failures++; $display("FAIL wr_en_idle got=%b exp=0", ram_write_en); end
        after_edge();
        checks++; if (rd_valid !== 4'b0010) begin failures++; $display("FAIL rd_valid_single got=%b exp=0010", rd_valid); end
        checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL rd_data_single got=%h exp=a5", rd_data); end
        clear_reqs();
        after_edge();
        checks++; if (rd_valid !== 4'b0) begin failures++; $display("FAIL rd_valid_pulse got=%b exp=0000", rd_valid); end
        checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL rd_data_hold got=%h exp=a5", rd_data); end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int c = 0; c < NREQ; c++) set_rd(c, c + 10);
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            checks++; if (rd_gnt !== onehot(cyc % NREQ)) begin failures++;
                $display("FAIL rr_gnt[%0d] got=%b exp=%b", cyc, rd_gnt, onehot(cyc % NREQ)); end
            after_edge();
            checks++; if (rd_valid !== onehot(cyc % NREQ)) begin failures++;
                $display("FAIL rr_valid[%0d] got=%b exp=%b", cyc, rd_valid, onehot(cyc % NREQ)); end
            checks++; if (rd_data !== m_mem[(cyc % NREQ) + 10]) begin failures++;
                $display("FAIL rr_data[%0d] got=%h exp=%h", cyc, rd_data, m_mem[(cyc % NREQ) + 10]); end
        end
        clear_reqs();
    endtask

    task automatic test_collision();
        logic [DW-1:0] exp_d;
        apply_reset();
        set_wr(0, 7, 8'h11);
        after_edge();
        m_mem[7] = 8'h11;
        clear_reqs();
        set_wr(0, 7, 8'h22);
        set_rd(3, 7);
        @(negedge clk);
        checks++; if (wr_gnt !== 4'b0001 || rd_gnt !== 4'b1000) begin failures++;
            $display("FAIL raw_gnts got=%b/%b exp=0001/1000", wr_gnt, rd_gnt); end
`ifdef RAW_BYPASS_EN
        exp_d = 8'h22;
`else
        exp_d = 8'h11;
`endif
        after_edge();
        m_mem[7] = 8'h22;
        checks++; if (rd_valid !== 4'b1000) begin failures++; $display("FAIL raw_valid got=%b exp=1000", rd_valid); end
        checks++; if (rd_data !== exp_d) begin failures++; $display("FAIL raw_data got=%h exp=%h", rd_data, exp_d); end
        clear_reqs();
        set_rd(3, 7);
        after_edge();
        checks++; if (rd_data !== 8'h22) begin failures++; $display("FAIL raw_reread got=%h exp=22", rd_data); end
        clear_reqs();
    endtask

    task automatic test_out_of_range();
        apply_reset();
        set_rd(2, 5);
        after_edge();
        checks++; if (rd_data !== m_mem[5]) begin failures++; $display("FAIL oor_pre got=%h exp=%h", rd_data, m_mem[5]); end
        clear_reqs();
        set_wr(1, 30, 8'h5A);
        @(negedge clk);
        checks++; if (wr_gnt !== 4'b0010) begin failures++; $display("FAIL oor_wr_gnt got=%b exp=0010", wr_gnt); end
        checks++; if (ram_write_en !== 1'b0) begin failures++; $display("FAIL oor_wr_en got=%b exp=0", ram_write_en); end
        after_edge();
        clear_reqs();
        set_rd(0, 30);
        @(negedge clk);
        checks++; if (rd_gnt !== 4'b0001) begin failures++; $display("FAIL oor_rd_gnt got=%b exp=0001", rd_gnt); end
        after_edge();
        checks++; if (rd_valid !== 4'b0001) begin failures++; $display("FAIL oor_rd_valid got=%b exp=0001", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL oor_rd_data got=%h exp=00", rd_data); end
        clear_reqs();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        set_rd(0, 3);
        after_edge();
        clear_reqs();
        for (int c = 0; c < NREQ; c++) set_rd(c, c + 1);
        @(negedge clk);
        checks++; if (rd_gnt !== 4'b0010) begin failures++; $display("FAIL mid_gnt got=%b exp=0010", rd_gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_gnt !== 4'b0) begin failures++; $display("FAIL mid_gnt_rst got=%b exp=0000", rd_gnt); end
        after_edge();
        checks++; if (rd_valid !== 4'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0000", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%h exp=00", rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (rd_gnt !== 4'b0001) begin failures++; $display("FAIL mid_first_gnt got=%b exp=0001", rd_gnt); end
        after_edge();
        checks++; if (rd_valid !== 4'b0001 || rd_data !== m_mem[1]) begin failures++;
            $display("FAIL mid_first_rd got=%b/%h exp=0001/%h", rd_valid, rd_data, m_mem[1]); end
        clear_reqs();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] wp, rp;
        int              wa [NREQ];
        int              wd [NREQ];
        int              ra [NREQ];
        int              mwp, mrp, wk, rk;
        logic [DW-1:0]   exp_rd;
        logic [AW-1:0]   exp_ia, exp_oa;
        logic [DW-1:0]   exp_id;
        logic            exp_we;
        apply_reset();
        wp = '0; rp = '0; mwp = 0; mrp = 0; exp_rd = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int c = 0; c < NREQ; c++) begin
                if (!wp[c] && $urandom_range(0, 1) == 1) begin
                    wp[c] = 1'b1;
                    wa[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 7));
                    wd[c] = int'($urandom_range(0, 255));
                end
                if (!rp[c] && $urandom_range(0, 1) == 1) begin
                    rp[c] = 1'b1;
                    ra[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 7));
                end
            end
            clear_reqs();
            for (int c = 0; c < NREQ; c++) begin
                if (wp[c]) set_wr(c, wa[c], wd[c]);
                if (rp[c]) set_rd(c, ra[c]);
            end
            wk = pick(wp, mwp);
            rk = pick(rp, mrp);
            exp_ia = (wk >= 0) ? AW'(wa[wk]) : '0;
            exp_id = (wk >= 0) ? DW'(wd[wk]) : '0;
            exp_oa = (rk >= 0) ? AW'(ra[rk]) : '0;
            exp_we = (wk >= 0) && (wa[wk] < DEPTH);
            @(negedge clk);
            checks++; if (wr_gnt !== onehot(wk) || rd_gnt !== onehot(rk)) begin failures++;
                $display("FAIL rnd_gnt[%0d] got=%b/%b exp=%b/%b", cyc, wr_gnt, rd_gnt, onehot(wk), onehot(rk)); end
            checks++; if (ram_write_en !== exp_we) begin failures++;
                $display("FAIL rnd_wr_en[%0d] got=%b exp=%b", cyc, ram_write_en, exp_we); end
            checks++; if (ram_in_addr !== exp_ia || ram_data_in !== exp_id || ram_out_addr !== exp_oa) begin
                failures++;
                $display("FAIL rnd_mux[%0d] got=%h/%h/%h exp=%h/%h/%h", cyc, ram_in_addr, ram_data_in,
                         ram_out_addr, exp_ia, exp_id, exp_oa);
            end
            if (rk >= 0) begin
                if (ra[rk] >= DEPTH) exp_rd = '0;
`ifdef RAW_BYPASS_EN
                else if (exp_we && wa[wk] == ra[rk]) exp_rd = DW'(wd[wk]);
`endif
                else exp_rd = m_mem[ra[rk]];
            end
            if (exp_we) m_mem[wa[wk]] = DW'(wd[wk]);
            if (wk >= 0) begin mwp = (wk + 1) % NREQ; wp[wk] = 1'b0; end
            if (rk >= 0) begin mrp = (rk + 1) % NREQ; rp[rk] = 1'b0; end
            after_edge();
            checks++; if (rd_valid !== onehot(rk)) begin failures++;
                $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, rd_valid, onehot(rk)); end
            checks++; if (rd_data !== exp_rd) begin failures++;
                $display("FAIL rnd_data[%0d] got=%h exp=%h", cyc, rd_data, exp_rd); end
        end
        clear_reqs();
    endtask

    initial begin
        clear_reqs();
        after_edge();
        do_preload();
        test_reset();
        test_write_read();
        test_fairness();
        test_collision();
        test_out_of_range();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
